cpu_tick_gen: RTL and testbench

Parametrised execution-rate generator for the single-cycle RV32I core on the 50 MHz board. Emits a one-cycle clock-enable pulse `tick_o`; no derived clock is produced. It supports manual single-step from a push-button and automatic run at a switch-selected rate. It sits between board I/O (button, switches, LED) and the core's enable input, and the whole design stays on `clk_in`.

---
 rtl/cpu_tick_pkg.sv | 46 ++++
 rtl/btn_debouncer.sv | 58 +++++
 rtl/cpu_tick_gen.sv | 147 ++++++++++++++
 tb/tb_cpu_tick_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_tick_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_tick_pkg
// Brief    : Shared types and rate-table helpers for the CPU tick generator.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_tick_pkg;

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } tick_state_t;

    localparam int unsigned RATE_N = 4;

    // A zero entry marks full speed; selectors past the table also run full speed.
    localparam int unsigned RATE_HZ [RATE_N] = '{1, 10, 1_000, 0};

    function automatic int unsigned div_for(input int unsigned sel, input int unsigned clk_hz);
        int unsigned d;
        if (sel >= RATE_N) begin
            d = 1;
        end else if (RATE_HZ[sel] == 0) begin
            d = 1;
        end else begin
            d = clk_hz / RATE_HZ[sel];
        end
        if (d == 0) begin
            d = 1;
        end
        return d;
    endfunction

    function automatic int unsigned max_div(input int unsigned n_sel, input int unsigned clk_hz);
        int unsigned m;
        m = 1;
        for (int unsigned s = 0; s < n_sel; s++) begin
            if (div_for(s, clk_hz) > m) begin
                m = div_for(s, clk_hz);
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : btn_debouncer
// Brief    : 2-flop synchroniser, stability filter and rising-edge pulse for
//            the step button. Filter enabled by CPU_TICK_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

`ifdef CPU_TICK_DEBOUNCE_EN
    localparam bit C_FILTER_EN = 1'b1;
`else
    localparam bit C_FILTER_EN = 1'b0;
`endif

    // With the filter off the limit collapses to zero and the level is a plain register stage.
    localparam int unsigned C_LIMIT = C_FILTER_EN ? DEBOUNCE_CYCLES : 0;
    localparam int C_CNT_W = (C_LIMIT > 0) ? $clog2(C_LIMIT + 1) : 1;

    logic               r_s1;
    logic               r_s2;
    logic               r_db;
    logic               r_db_q;
    logic [C_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_db   <= 1'b0;
            r_db_q <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= btn_i;
            r_s2   <= r_s1;
            r_db_q <= r_db;
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_W'(C_LIMIT)) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + C_CNT_W'(1);
            end
        end
    end

    assign pulse_o = r_db & ~r_db_q;

endmodule
`default_nettype wire

// File: rtl/cpu_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : cpu_tick_gen
// Brief    : Clock-enable tick generator with manual step and selectable auto
//            rate. Button filter enabled by CPU_TICK_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_tick_gen
    import cpu_tick_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int          RATE_SEL_W      = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  run_i,
    input  logic                  step_btn_i,
    input  logic [RATE_SEL_W-1:0] rate_sel_i,
    output logic                  tick_o,
    output logic                  running_o,
    output logic                  led_o,
    output logic [31:0]           tick_count_o
);

    localparam int unsigned C_N_SEL   = 2 ** RATE_SEL_W;
    localparam int unsigned C_MAX_DIV = max_div(C_N_SEL, CLK_HZ);
    localparam int          C_CNT_W   = (C_MAX_DIV > 1) ? $clog2(C_MAX_DIV) : 1;

    logic                  r_run_s1;
    logic                  r_run_s2;
    logic [RATE_SEL_W-1:0] r_rate_s1;
    logic [RATE_SEL_W-1:0] r_rate_s2;
    logic [RATE_SEL_W-1:0] r_rate_q;

    tick_state_t           r_state;
    tick_state_t           w_state_nxt;
    logic [C_CNT_W-1:0]    r_cnt;
    logic [C_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_tick_nxt;
    logic                  w_step_pulse;
    logic [C_CNT_W-1:0]    w_div_m1;
    logic [C_CNT_W-1:0]    w_div_m1_tbl [C_N_SEL];

    logic                  r_tick;
    logic                  r_running;
    logic                  r_led;
    logic [31:0]           r_tick_count;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debouncer (
        .clk_in  (clk_in),
        .rst     (rst),
        .btn_i   (step_btn_i),
        .pulse_o (w_step_pulse)
    );

    for (genvar g = 0; g < C_N_SEL; g++) begin : g_div_tbl
        localparam int unsigned C_DIV_M1 = div_for(g, CLK_HZ) - 1;
        assign w_div_m1_tbl[g] = C_CNT_W'(C_DIV_M1);
    end

    assign w_div_m1 = w_div_m1_tbl[r_rate_s2];

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_run_s1  <= 1'b0;
            r_run_s2  <= 1'b0;
            r_rate_s1 <= '0;
            r_rate_s2 <= '0;
            r_rate_q  <= '0;
        end else begin
            r_run_s1  <= run_i;
            r_run_s2  <= r_run_s1;
            r_rate_s1 <= rate_sel_i;
            r_rate_s2 <= r_rate_s1;
            r_rate_q  <= r_rate_s2;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= MANUAL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Mode change and rate change both take priority over a due auto tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tick_nxt  = 1'b0;
        case (r_state)
            MANUAL: begin
                w_tick_nxt = w_step_pulse;
                if (r_run_s2) begin
                    w_state_nxt = AUTO;
                    w_cnt_nxt   = '0;
                end
            end
            AUTO: begin
                if (!r_run_s2) begin
                    w_state_nxt = MANUAL;
                    w_cnt_nxt   = '0;
                end else if (r_rate_s2 != r_rate_q) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == w_div_m1) begin
                    w_tick_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = MANUAL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_tick       <= 1'b0;
            r_running    <= 1'b0;
            r_led        <= 1'b0;
            r_tick_count <= '0;
        end else begin
            r_tick    <= w_tick_nxt;
            r_running <= (w_state_nxt == AUTO);
            if (w_tick_nxt) begin
                r_led        <= ~r_led;
                r_tick_count <= r_tick_count + 32'd1;
            end
        end
    end

    assign tick_o       = r_tick;
    assign running_o    = r_running;
    assign led_o        = r_led;
    assign tick_count_o = r_tick_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_tick_gen
// Brief    : Directed self-checking bench for cpu_tick_gen at CLK_HZ = 10 kHz.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_tick_gen;

    localparam int unsigned DB = 4;
`ifdef CPU_TICK_DEBOUNCE_EN
    localparam int LIM   = DB;
    localparam bit DB_EN = 1'b1;
`else
    localparam int LIM   = 0;
    localparam bit DB_EN = 1'b0;
`endif

    logic        clk_in     = 1'b0;
    logic        rst        = 1'b1;
    logic        run_i      = 1'b0;
    logic        step_btn_i = 1'b0;
    logic [1:0]  rate_sel_i = 2'd2;
    logic        tick_o;
    logic        running_o;
    logic        led_o;
    logic [31:0] tick_count_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          nticks;
    logic [31:0] exp_count;
    logic        exp_led;
    bit          exp_t;
    int          e0;

    cpu_tick_gen #(
        .CLK_HZ          (10_000),
        .RATE_SEL_W      (2),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .run_i        (run_i),
        .step_btn_i   (step_btn_i),
        .rate_sel_i   (rate_sel_i),
        .tick_o       (tick_o),
        .running_o    (running_o),
        .led_o        (led_o),
        .tick_count_o (tick_count_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_tick(input bit t);
        if (t) begin
            exp_count = exp_count + 32'd1;
            exp_led   = ~exp_led;
        end
    endtask

    initial begin
        exp_count = '0;
        exp_led   = 1'b0;

        // Reset and idle in manual mode
        repeat (3) @(negedge clk_in);
        chk("rst_tick", {31'b0, tick_o}, 0);
        chk("rst_running", {31'b0, running_o}, 0);
        chk("rst_led", {31'b0, led_o}, 0);
        chk("rst_count", tick_count_o, 0);
        rst = 1'b0;
        nticks = 0;
        repeat (100) begin
            @(negedge clk_in);
            if (tick_o) nticks++;
        end
        chk("idle_ticks", nticks, 0);
        chk("idle_count", tick_count_o, 0);
        chk("idle_running", {31'b0, running_o}, 0);

        // Bouncy press 1,0,1 then held; i indexes the edge that samples the input
        for (int i = 0; i < 23; i++) begin
            step_btn_i = (i == 1) ? 1'b0 : 1'b1;
            @(negedge clk_in);
            exp_t = DB_EN ? (i == 9) : (i == 3 || i == 5);
            chk($sformatf("step_tick_e%0d", i), {31'b0, tick_o}, {31'b0, exp_t});
            model_tick(exp_t);
        end
        chk("step_count", tick_count_o, exp_count);
        chk("step_led", {31'b0, led_o}, {31'b0, exp_led});
        nticks = 0;
        repeat (500) begin
            @(negedge clk_in);
            if (tick_o) nticks++;
        end
        chk("hold_ticks", nticks, 0);
        step_btn_i = 1'b0;
        repeat (20) @(negedge clk_in);

        // Auto at sel 2 (DIV 10), then leave on the cycle the counter is 9
        // with a debounced button edge landing in that same cycle
        e0 = 110 - 1 - LIM;
        for (int i = 0; i <= 150; i++) begin
            run_i      = (i < 110);
            step_btn_i = (i >= e0);
            @(negedge clk_in);
            exp_t = (i >= 12 && i <= 102 && ((i - 12) % 10) == 0);
            chk($sformatf("auto_tick_e%0d", i), {31'b0, tick_o}, {31'b0, exp_t});
            chk($sformatf("auto_run_e%0d", i), {31'b0, running_o},
                {31'b0, (i >= 2 && i <= 111)});
            model_tick(exp_t);
            if (i == 102) chk("auto_count_100", tick_count_o, exp_count);
        end
        chk("leave_count", tick_count_o, exp_count);
        chk("leave_led", {31'b0, led_o}, {31'b0, exp_led});
        step_btn_i = 1'b0;
        repeat (20) @(negedge clk_in);

        // Rate change sel 2 -> 3 mid-period
        for (int j = 0; j <= 40; j++) begin
            run_i      = 1'b1;
            rate_sel_i = (j >= 25) ? 2'd3 : 2'd2;
            @(negedge clk_in);
            exp_t = (j == 12 || j == 22 || j >= 28);
            chk($sformatf("rate_tick_e%0d", j), {31'b0, tick_o}, {31'b0, exp_t});
            model_tick(exp_t);
        end
        chk("rate_count", tick_count_o, exp_count);

        // Asynchronous reset while ticking every cycle
        rst = 1'b1;
        #1;
        chk("arst_tick", {31'b0, tick_o}, 0);
        chk("arst_running", {31'b0, running_o}, 0);
        chk("arst_led", {31'b0, led_o}, 0);
        chk("arst_count", tick_count_o, 0);
        run_i      = 1'b0;
        step_btn_i = 1'b0;
        exp_count  = '0;
        exp_led    = 1'b0;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("post_rst_count", tick_count_o, 0);
        chk("post_rst_running", {31'b0, running_o}, 0);

        // Tick counter wrap from all-ones
        force dut.r_tick_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_tick_count;
        exp_count = 32'hFFFF_FFFF;
        for (int k = 0; k < 16; k++) begin
            step_btn_i = 1'b1;
            @(negedge clk_in);
            exp_t = (k == 3 + LIM);
            chk($sformatf("wrap_tick_e%0d", k), {31'b0, tick_o}, {31'b0, exp_t});
            model_tick(exp_t);
        end
        chk("wrap_count", tick_count_o, exp_count);
        chk("wrap_led", {31'b0, led_o}, {31'b0, exp_led});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
